// File: rtl/spi_game_pkg.sv
// Shared types and constants for the SPI game-data receiver.
package spi_game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int B_GAME_STATUS = 0;
  localparam int B_JUMP        = 1;
  localparam int B_ACC         = 2;

  localparam logic [7:0] TRAILER_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_game_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from one extra history flop.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Resetting to 0 means a pin already low at reset release produces no fall edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_game_rx.sv
// SPI mode-0 slave oversampled in the LCD clock domain; receives a fixed-length
// game frame and commits it atomically to the display controller inputs.
module spi_game_rx
  import spi_game_pkg::*;
#(
  parameter int          N_BYTES     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  TRAILER     = TRAILER_DEFAULT
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iSPI_SCK,
  input  logic       iSPI_CS_n,
  input  logic       iSPI_MOSI,
  output logic       oSPI_MISO,
  output logic       oSPI_MISO_oe,
  input  logic [7:0] iTX_status,
  output logic [7:0] oSPI_game_status,
  output logic [7:0] oSPI_jump,
  output logic [7:0] oSPI_acc,
  output logic       oFrame_valid,
  output logic       oFrame_err,
  output logic [7:0] oFrame_cnt
);

  localparam int                BC_W    = $clog2(N_BYTES + 2);
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(N_BYTES);
  localparam logic [BC_W-1:0]   BC_SAT  = BC_W'(N_BYTES + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(iCLK), .rst_n(iRST_n), .din(iSPI_SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(iCLK), .rst_n(iRST_n), .din(iSPI_CS_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(iCLK), .rst_n(iRST_n), .din(iSPI_MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      rx_shift;
  logic [7:0]      tx_shift;
  logic [7:0]      shadow [N_BYTES];
  logic            cs_pend;
  logic [7:0]      rx_byte;

  assign rx_byte = {rx_shift[6:0], mosi_lvl};

  // Frame FSM, shift registers and atomic commit of the shadow bytes.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      byte_cnt         <= '0;
      rx_shift         <= 8'h00;
      tx_shift         <= 8'h00;
      cs_pend          <= 1'b0;
      for (int i = 0; i < N_BYTES; i++) shadow[i] <= 8'h00;
      oSPI_MISO        <= 1'b0;
      oSPI_MISO_oe     <= 1'b0;
      oSPI_game_status <= 8'h00;
      oSPI_jump        <= 8'h00;
      oSPI_acc         <= 8'h00;
      oFrame_valid     <= 1'b0;
      oFrame_err       <= 1'b0;
      oFrame_cnt       <= 8'h00;
    end else begin
      oFrame_valid <= 1'b0;
      oFrame_err   <= 1'b0;
      case (state)
        IDLE: begin
          cs_pend <= 1'b0;
          if (cs_fall || cs_pend) begin
            state        <= ACTIVE;
            bit_cnt      <= 3'd0;
            byte_cnt     <= '0;
            tx_shift     <= iTX_status;
            oSPI_MISO    <= iTX_status[7];
            oSPI_MISO_oe <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // CS release takes priority over any SCK edge seen in the same cycle.
            state        <= DONE;
            oSPI_MISO    <= 1'b0;
            oSPI_MISO_oe <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              for (int i = 0; i < N_BYTES; i++) begin
                if (byte_cnt == BC_W'(i)) shadow[i] <= rx_byte;
              end
              if (byte_cnt != BC_SAT) byte_cnt <= byte_cnt + BC_W'(1);
              tx_shift <= (byte_cnt == BC_W'(B_JUMP - 1)) ? oFrame_cnt : TRAILER;
            end
          end else if (sck_fall) begin
            // On a byte boundary the freshly loaded byte's MSB goes out unshifted.
            if (bit_cnt == 3'd0) begin
              oSPI_MISO <= tx_shift[7];
            end else begin
              tx_shift  <= {tx_shift[6:0], 1'b0};
              oSPI_MISO <= tx_shift[6];
            end
          end
        end
        DONE: begin
          cs_pend <= cs_fall;
          state   <= IDLE;
          if (byte_cnt == BC_LAST && bit_cnt == 3'd0) begin
            oSPI_game_status <= shadow[B_GAME_STATUS];
            oSPI_jump        <= shadow[B_JUMP];
            oSPI_acc         <= shadow[B_ACC];
            oFrame_valid     <= 1'b1;
            oFrame_cnt       <= oFrame_cnt + 8'd1;
          end else begin
            oFrame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_game_rx.md
Name: spi_game_rx

Overview:
- SPI slave sitting directly upstream of the MTL/Avalon display controller. The PIC32 master sends fixed-length frames.
- Each frame carries game_status, jump and accelerometer bytes. This block oversamples the SPI pins in the LCD clock domain.
- The received bytes are committed atomically into the registers that drive the controller's iSPI_game_status / iSPI_jump / iSPI_acc inputs.
- A status byte is returned to the master on MISO during the same frame.

Parameters:
- N_BYTES, 3, data bytes per frame. Byte order: 0 = game_status, 1 = jump, 2 = acc. Bytes with index ≥3 are received and ignored.
- SYNC_STAGES, 2, synchronizer flops per SPI input pin (min 2).
- TRAILER, 8'hA5, MISO byte returned for byte index ≥2.

Ports:
- iCLK  in  1  LCD control clock (33 MHz); the only clock.
- iRST_n  in  1  reset; synchronous, active-low.
- iSPI_SCK  in  1  SPI clock from master. Asynchronous; mode 0 (CPOL=0, CPHA=0).
- iSPI_CS_n  in  1  chip select, active-low, asynchronous.
- iSPI_MOSI  in  1  master-out data, MSB first.
- oSPI_MISO  out  1  slave-out data, MSB first.
- oSPI_MISO_oe  out  1  MISO output enable; high only while CS is asserted.
- iTX_status  in  8  status byte returned in frame byte 0 (e.g. {KO_qb, state_qb, done_move}). Sampled at CS fall.
- oSPI_game_status  out  8  committed byte 0.
- oSPI_jump  out  8  committed byte 1.
- oSPI_acc  out  8  committed byte 2.
- oFrame_valid  out  1  one-cycle pulse when a frame commits.
- oFrame_err  out  1  one-cycle pulse when a frame is rejected.
- oFrame_cnt  out  8  count of committed frames; wraps 255→0.

Behaviour:
- Input synchronization
  - SCK, CS_n and MOSI each pass through SYNC_STAGES flops, plus one extra flop for edge detection.
  - Edge signals: sck_rise, sck_fall, cs_fall, cs_rise, each one iCLK cycle wide.
  - Supported SCK rate: ≤ iCLK/8.
- States: IDLE, ACTIVE, DONE.
  - IDLE → ACTIVE on cs_fall. On entry: clear bit_cnt (3b) and byte_cnt; load tx_shift with iTX_status; drive oSPI_MISO = iTX_status[7]; assert oSPI_MISO_oe.
  - ACTIVE:
    - On sck_rise: rx_shift <= {rx_shift[6:0], MOSI_sync}; bit_cnt++.
    - When bit_cnt wraps 7→0: store the completed byte into shadow[byte_cnt] if byte_cnt<N_BYTES; byte_cnt++, saturating at N_BYTES+1.
    - On sck_fall: shift tx_shift left and drive its MSB.
    - At a byte boundary, the next tx byte is loaded: oFrame_cnt for byte 1, TRAILER for byte ≥2.
  - ACTIVE → DONE on cs_rise. oSPI_MISO_oe deasserts in the same cycle.
  - DONE lasts one cycle, then → IDLE.
    - Commit if byte_cnt==N_BYTES and bit_cnt==0: copy the shadow registers to the outputs, pulse oFrame_valid, increment oFrame_cnt.
    - Otherwise (short frame, partial byte, or extra bytes): pulse oFrame_err; outputs and oFrame_cnt unchanged.
- Latency: committed outputs and oFrame_valid become visible on the iCLK edge after the edge-detected cs_rise, i.e. SYNC_STAGES+2 iCLK edges after CS_n is sampled high at the pin.
- Outputs never change except in DONE, so the downstream controller never sees a mixed old/new frame.
- Simultaneous events:
  - cs_rise and sck_rise detected in the same cycle: cs_rise wins and the SCK edge is ignored.
  - cs_fall while in DONE: taken on the following cycle (the CS sync lag guarantees it is not lost).
- Reset: all outputs 0, oSPI_MISO_oe 0, state IDLE, shadow registers 0.
  - Reset asserted mid-frame aborts the frame. No commit and no err pulse.
  - After reset, the block waits for a fresh cs_fall; a CS already low at reset release is ignored until it rises.
- SCK edges seen while CS is high are ignored.

Decomposition:
- Package spi_game_pkg:
  - state enum {IDLE, ACTIVE, DONE};
  - byte index localparams (B_GAME_STATUS=0, B_JUMP=1, B_ACC=2);
  - TRAILER default.
- Sub-module spi_sync_edge (one instance per pin): SYNC_STAGES synchronizer plus rise/fall pulse outputs.
- Top-level holds the FSM, the shift registers and the commit logic.

Test Plan:
- Reset: hold iRST_n low 4 cycles → all outputs 0, oSPI_MISO_oe 0, no pulses.
- Good frame: iTX_status=8'h3C; send 8'h02, 8'h05, 8'hF1 at SCK=iCLK/8.
  - oSPI_game_status=8'h02, oSPI_jump=8'h05, oSPI_acc=8'hF1.
  - One oFrame_valid pulse 4 edges after CS high; oFrame_cnt=1.
  - Master receives 8'h3C, 8'h00, 8'hA5.
- Short frame: after a good frame, send 20 bits then raise CS → oFrame_err pulse; outputs keep previous values; oFrame_cnt unchanged.
- Long frame: send 4 bytes 8'h11, 8'h22, 8'h33, 8'h44 → oFrame_err; no update.
- Counter wrap: 256 good frames → oFrame_cnt returns to 0; the second frame returns 8'h01 in MISO byte 1.
- Reset mid-frame after 12 bits, then release with CS still low, then a full good frame → first CS period ignored; the good frame commits normally; no err pulse for the aborted one.
